// File: rtl/cpu_write_sb.sv
`default_nettype none
// ============================================================================
// Module   : cpu_write_sb
// Purpose  : Writeback stage with an in-order posted store buffer and a
//            memory bus port. Optional store-to-load forwarding is enabled
//            by defining CPU_WRITE_SB_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_write_sb #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SB_DEPTH        = 4,
    parameter int REG_INDEX_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [REG_INDEX_WIDTH-1:0] register_write_index_i,
    input  logic                       register_we_i,
    input  logic                       memory_we_i,
    input  logic                       loadp_i,
    input  logic [ADDR_WIDTH-1:0]      memory_address_i,
    input  logic [DATA_WIDTH-1:0]      result_i,
    output logic                       stall_o,
    output logic [REG_INDEX_WIDTH-1:0] register_write_index_o,
    output logic                       register_we_o,
    output logic [DATA_WIDTH-1:0]      result_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0]      mem_data_o,
    input  logic                       mem_ack_i,
    input  logic [DATA_WIDTH-1:0]      mem_data_i,
    output logic                       sb_empty_o
);

    localparam int c_ptr_w = $clog2(SB_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(SB_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t                       r_state;
    logic [ADDR_WIDTH-1:0]        r_sb_addr [SB_DEPTH];
    logic [DATA_WIDTH-1:0]        r_sb_data [SB_DEPTH];
    logic [c_ptr_w-1:0]           r_head;
    logic [c_ptr_w-1:0]           r_tail;
    logic [c_cnt_w-1:0]           r_count;
    logic                         r_sb_empty;
    logic                         r_reg_we;
    logic [REG_INDEX_WIDTH-1:0]   r_reg_idx;
    logic [DATA_WIDTH-1:0]        r_result;
    logic                         r_mem_req;
    logic                         r_mem_we;
    logic [ADDR_WIDTH-1:0]        r_mem_addr;
    logic [DATA_WIDTH-1:0]        r_mem_data;

    logic                         w_is_load;
    logic                         w_is_store;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_fwd_hit;
    logic [DATA_WIDTH-1:0]        w_fwd_data;
    logic                         w_load_eligible;
    logic                         w_read_ack;
    logic                         w_accept_ok;
    logic                         w_accept;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_read_start;
    logic [DATA_WIDTH-1:0]        w_load_data;
    logic [c_cnt_w-1:0]           w_count_next;

    // A load with the store flag also set is a load; the store half is dropped.
    assign w_is_load  = loadp_i;
    assign w_is_store = memory_we_i & ~loadp_i;
    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);

`ifdef CPU_WRITE_SB_FORWARD_EN
    logic [c_ptr_w-1:0] w_scan_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_scan_idx = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_scan_idx = r_head + c_ptr_w'(i);
            if ((c_cnt_w'(i) < r_count) && (r_sb_addr[w_scan_idx] == memory_address_i)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_sb_data[w_scan_idx];
            end
        end
    end
    assign w_load_eligible = 1'b1;
`else
    assign w_fwd_hit       = 1'b0;
    assign w_fwd_data      = '0;
    assign w_load_eligible = w_empty;
`endif

    assign w_read_ack   = (r_state == S_READ) & mem_ack_i;
    assign w_accept_ok  = w_is_load  ? (w_fwd_hit | w_read_ack) :
                          w_is_store ? ~w_full : 1'b1;
    assign stall_o      = valid_i & ~w_accept_ok;
    assign w_accept     = valid_i & w_accept_ok;
    assign w_push       = w_accept & w_is_store;
    assign w_pop        = (r_state == S_WRITE) & mem_ack_i;
    assign w_read_start = valid_i & w_is_load & ~w_fwd_hit & w_load_eligible;
    assign w_load_data  = w_fwd_hit ? w_fwd_data : mem_data_i;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + c_cnt_one;
        else if (w_pop && !w_push)
            w_count_next = r_count - c_cnt_one;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_sb_addr[r_tail] <= memory_address_i;
            r_sb_data[r_tail] <= result_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_sb_empty <= 1'b1;
            r_reg_we   <= 1'b0;
            r_reg_idx  <= '0;
            r_result   <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + c_ptr_one;
            if (w_pop)
                r_head <= r_head + c_ptr_one;
            r_count    <= w_count_next;
            r_sb_empty <= (w_count_next == '0);

            r_reg_we <= w_accept & register_we_i;
            if (w_accept) begin
                r_reg_idx <= register_write_index_i;
                r_result  <= w_is_load ? w_load_data : result_i;
            end

            // Bus signals are held until ack; returning to IDLE guarantees a gap cycle.
            case (r_state)
                S_IDLE: begin
                    if (w_read_start) begin
                        r_state    <= S_READ;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= memory_address_i;
                    end else if (!w_empty) begin
                        r_state    <= S_WRITE;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_sb_addr[r_head];
                        r_mem_data <= r_sb_data[r_head];
                    end
                end
                S_WRITE, S_READ: begin
                    if (mem_ack_i) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign register_we_o          = r_reg_we;
    assign register_write_index_o = r_reg_idx;
    assign result_o               = r_result;
    assign mem_req_o              = r_mem_req;
    assign mem_we_o               = r_mem_we;
    assign mem_addr_o             = r_mem_addr;
    assign mem_data_o             = r_mem_data;
    assign sb_empty_o             = r_sb_empty;

endmodule
`default_nettype wire

// File: tb/tb_cpu_write_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_write_sb
// Purpose  : Scoreboard bench for cpu_write_sb against an architectural
//            memory model (loads see the latest store in program order).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_write_sb;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  register_write_index_i = '0;
    logic        register_we_i = 1'b0;
    logic        memory_we_i = 1'b0;
    logic        loadp_i = 1'b0;
    logic [31:0] memory_address_i = '0;
    logic [31:0] result_i = '0;
    logic        stall_o;
    logic [3:0]  register_write_index_o;
    logic        register_we_o;
    logic [31:0] result_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic        sb_empty_o;

    cpu_write_sb dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .valid_i                (valid_i),
        .register_write_index_i (register_write_index_i),
        .register_we_i          (register_we_i),
        .memory_we_i            (memory_we_i),
        .loadp_i                (loadp_i),
        .memory_address_i       (memory_address_i),
        .result_i               (result_i),
        .stall_o                (stall_o),
        .register_write_index_o (register_write_index_o),
        .register_we_o          (register_we_o),
        .result_o               (result_o),
        .mem_req_o              (mem_req_o),
        .mem_we_o               (mem_we_o),
        .mem_addr_o             (mem_addr_o),
        .mem_data_o             (mem_data_o),
        .mem_ack_i              (mem_ack_i),
        .mem_data_i             (mem_data_i),
        .sb_empty_o             (sb_empty_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    logic [35:0] sbq [$];
    logic [63:0] wq [$];

    bit ack_hold_low = 1'b0;
    int fixed_lat    = -1;
    bit busy         = 1'b0;
    int wcnt         = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (slave_mem.exists(a)) return slave_mem[a];
        return init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave with random or fixed latency; ack only while a request is up.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_i) begin
                mem_ack_i = 1'b0;
                busy = 1'b0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
            end else if (mem_req_o && !ack_hold_low) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
                end
                if (wcnt == 0) begin
                    mem_ack_i = 1'b1;
                    busy = 1'b0;
                    if (!mem_we_o) mem_data_i = slave_rd(mem_addr_o);
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Monitor: writeback scoreboard and bus write ordering.
    initial begin
        forever begin
            @(negedge clk);
            if (register_we_o) begin
                if (sbq.size() == 0) begin
                    check("wb_unexpected", {28'd0, register_write_index_o, result_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [35:0] e;
                    e = sbq.pop_front();
                    check("wb_data", {28'd0, register_write_index_o, result_o}, {28'd0, e});
                end
            end
            if (!rst_i && mem_req_o && mem_ack_i && mem_we_o) begin
                if (wq.size() == 0) begin
                    check("bus_write_unexpected", {mem_addr_o, mem_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [63:0] w;
                    w = wq.pop_front();
                    check("bus_write", {mem_addr_o, mem_data_o}, w);
                end
                slave_mem[mem_addr_o] = mem_data_o;
            end
        end
    end

    task automatic drive(input bit ld, input bit st, input logic [3:0] idx,
                         input logic [31:0] addr, input logic [31:0] data);
        valid_i                = 1'b1;
        loadp_i                = ld;
        memory_we_i            = st;
        register_we_i          = 1'b1;
        register_write_index_i = idx;
        memory_address_i       = addr;
        result_i               = data;
    endtask

    // Entered at a negedge with an instruction driven; returns at posedge+1.
    task automatic wait_accept();
        int cyc;
        logic [31:0] exp;
        cyc = 0;
        while (stall_o) begin
            cyc++;
            if (cyc > 300) begin
                check("accept_timeout", 64'd1, 64'd0);
                @(posedge clk); #1;
                valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (loadp_i) begin
            exp = model_rd(memory_address_i);
        end else begin
            exp = result_i;
            if (memory_we_i) begin
                mem_model[memory_address_i] = result_i;
                wq.push_back({memory_address_i, result_i});
            end
        end
        sbq.push_back({register_write_index_i, exp});
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic issue(input bit ld, input bit st, input logic [3:0] idx,
                         input logic [31:0] addr, input logic [31:0] data);
        drive(ld, st, idx, addr, data);
        @(negedge clk);
        wait_accept();
    endtask

    task automatic wait_empty();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!(sb_empty_o && !mem_req_o && sbq.size() == 0 && wq.size() == 0)) begin
            cyc++;
            if (cyc > 500) begin
                check("drain_timeout", 64'd1, 64'd0);
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_i = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst_i = 1'b0;
        busy = 1'b0;
        sbq.delete();
        wq.delete();
        mem_model = slave_mem;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int cyc;

        // Reset state
        @(posedge clk); #1;
        do_reset(2);
        @(negedge clk);
        check("rst_reg_we",   {63'd0, register_we_o}, 64'd0);
        check("rst_reg_idx",  {60'd0, register_write_index_o}, 64'd0);
        check("rst_result",   {32'd0, result_o}, 64'd0);
        check("rst_mem_req",  {63'd0, mem_req_o}, 64'd0);
        check("rst_mem_we",   {63'd0, mem_we_o}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
        check("rst_mem_data", {32'd0, mem_data_o}, 64'd0);
        check("rst_sb_empty", {63'd0, sb_empty_o}, 64'd1);
        check("rst_stall",    {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;

        // Non-memory instruction
        issue(1'b0, 1'b0, 4'd3, 32'h0, 32'h1234);
        @(negedge clk);
        check("nonmem_we",  {63'd0, register_we_o}, 64'd1);
        check("nonmem_idx", {60'd0, register_write_index_o}, 64'd3);
        check("nonmem_res", {32'd0, result_o}, 64'h1234);
        @(posedge clk); #1;

        // Full buffer stalls the fifth store; writes drain in order
        ack_hold_low = 1'b1;
        for (int i = 0; i < 4; i++)
            issue(1'b0, 1'b1, 4'd1, 32'h10 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
        drive(1'b0, 1'b1, 4'd1, 32'h20, 32'hC0DE_0004);
        @(negedge clk);
        check("full_stall", {63'd0, stall_o}, 64'd1);
        ack_hold_low = 1'b0;
        wait_accept();
        wait_empty();

        // Two stores to the same address then a load of it
        ack_hold_low = 1'b1;
        issue(1'b0, 1'b1, 4'd2, 32'h40, 32'hAAAA);
        issue(1'b0, 1'b1, 4'd2, 32'h40, 32'hBBBB);
        drive(1'b1, 1'b0, 4'd5, 32'h40, 32'h0);
        @(negedge clk);
`ifdef CPU_WRITE_SB_FORWARD_EN
        check("fwd_no_stall", {63'd0, stall_o}, 64'd0);
        wait_accept();
        ack_hold_low = 1'b0;
`else
        check("nofwd_stall", {63'd0, stall_o}, 64'd1);
        ack_hold_low = 1'b0;
        wait_accept();
`endif
        @(negedge clk);
        check("ld_youngest", {32'd0, result_o}, 64'hBBBB);
        wait_empty();

        // Load miss behind an in-flight write
        slave_mem[32'h80] = 32'hDEAD;
        mem_model[32'h80] = 32'hDEAD;
        fixed_lat = 2;
        issue(1'b0, 1'b1, 4'd6, 32'h200, 32'h5555);
        drive(1'b1, 1'b0, 4'd7, 32'h80, 32'h0);
        @(negedge clk);
        cyc = 0;
        while (stall_o && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("miss_ack_cycle", {62'd0, mem_ack_i, mem_we_o}, 64'd2);
        check("miss_rd_addr",   {32'd0, mem_addr_o}, 64'h80);
        wait_accept();
        @(negedge clk);
        check("miss_result", {32'd0, result_o}, 64'hDEAD);
        fixed_lat = -1;
        wait_empty();

        // Reset in the middle of a write with buffered stores
        ack_hold_low = 1'b1;
        for (int i = 0; i < 3; i++)
            issue(1'b0, 1'b1, 4'd8, 32'h300 + 32'(i * 4), 32'h7700 + 32'(i));
        cyc = 0;
        @(negedge clk);
        while (!mem_req_o && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        do_reset(1);
        @(negedge clk);
        check("midrst_req",   {63'd0, mem_req_o}, 64'd0);
        check("midrst_empty", {63'd0, sb_empty_o}, 64'd1);
        ack_hold_low = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Randomised mix of instructions
        for (int n = 0; n < 400; n++) begin
            int k;
            k = int'($urandom_range(0, 99));
            a = 32'h100 + 32'($urandom_range(0, 7) * 4);
            if (k < 40)
                issue(1'b0, 1'b0, 4'($urandom_range(0, 15)), a, $urandom);
            else if (k < 70)
                issue(1'b0, 1'b1, 4'($urandom_range(0, 15)), a, $urandom);
            else if (k < 95)
                issue(1'b1, 1'b0, 4'($urandom_range(0, 15)), a, $urandom);
            else
                issue(1'b1, 1'b1, 4'($urandom_range(0, 15)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_empty();
        check("final_wb_queue", 64'(sbq.size()), 64'd0);
        check("final_wr_queue", 64'(wq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_write_sb.md
# cpu_write_sb

Parametrised writeback stage with a real data-memory port. Stores are posted into an in-order store buffer and drained to the memory bus in the background. Loads complete either by forwarding from the buffer or by a stalling bus read. Sits at the end of the moxie pipeline, feeding the register file write port and back-pressuring upstream stages through `stall_o`.

## Interface

Parameters:
- `DATA_WIDTH`, 32: data and result width.
- `ADDR_WIDTH`, 32: memory address width.
- `SB_DEPTH`, 4: store-buffer entries; a power of two, at least 2.
- `REG_INDEX_WIDTH`, 4: register index width.

Ports:
- `clk_i`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous active-high reset.
- `valid_i`  in  1  an instruction is presented this cycle.
- `register_write_index_i`  in  REG_INDEX_WIDTH  destination register.
- `register_we_i`  in  1  instruction writes a register.
- `memory_we_i`  in  1  instruction is a store.
- `loadp_i`  in  1  instruction is a load.
- `memory_address_i`  in  ADDR_WIDTH  load/store word address.
- `result_i`  in  DATA_WIDTH  ALU result or store data.
- `stall_o`  out  1  instruction not accepted; upstream holds all inputs stable.
- `register_write_index_o`  out  REG_INDEX_WIDTH  registered destination index.
- `register_we_o`  out  1  registered write enable, one-cycle pulse per retired instruction.
- `result_o`  out  DATA_WIDTH  registered writeback value.
- `mem_req_o`  out  1  bus request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  ADDR_WIDTH  bus address.
- `mem_data_o`  out  DATA_WIDTH  bus write data.
- `mem_ack_i`  in  1  bus completion; read data is valid in the same cycle.
- `mem_data_i`  in  DATA_WIDTH  bus read data.
- `sb_empty_o`  out  1  store buffer empty and no write in flight (used for fences).

## Operation

- **Accept.** An instruction is accepted when `valid_i` is high and `stall_o` is low. `stall_o = valid_i & !accept_ok`.
- **Non-memory instruction.** Always accepted. Next cycle: `register_we_o = register_we_i`, `register_write_index_o` updated, and `result_o = result_i`.
- **Store.**
  - Accepted when the buffer is not full. The entry written is {`memory_address_i`, `result_i`}, pushed at the tail.
  - A full buffer stalls the store, even if an entry pops in the same cycle. The stall lifts the following cycle.
  - Register writeback proceeds as for a non-memory instruction.
- **Load with `loadp_i` and `memory_we_i` both high.** Treated as a load; the store is dropped.
- **Load, forwarding compiled in.**
  - The load address is compared against all valid entries. Comparison is full-width equality.
  - Hit: the youngest matching entry's data is forwarded. The load is accepted the same cycle and `result_o` = forwarded data next cycle.
  - Miss: the load stalls until the FSM is IDLE, then starts a READ.
- **Load, forwarding compiled out.** Covered under Configuration.
- **Read completion.** The load is accepted in the cycle `mem_ack_i` is high in READ. `result_o = mem_data_i` next cycle.
- **FSM states: IDLE, WRITE, READ.**
  - IDLE → READ: a pending load is eligible. Loads take priority over draining.
  - IDLE → WRITE: otherwise, if the buffer is non-empty. The head entry is registered onto the bus with `mem_req_o=1`, `mem_we_o=1`.
  - WRITE → IDLE on `mem_ack_i`, popping the head.
  - READ → IDLE on `mem_ack_i`.
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_data_o` are held stable until acknowledged. `mem_req_o` drops the cycle after ack.
  - At least one IDLE cycle separates bus transactions.
- **Pointers.** Head and tail are log2(SB_DEPTH) bits wide and wrap modulo SB_DEPTH. The count is log2(SB_DEPTH)+1 bits. Push and pop in the same cycle leave the count unchanged.
- **Reset.**
  - Empties the buffer and returns the FSM to IDLE. Any in-flight request is abandoned; the bus slave must tolerate this.
  - Posted stores are lost.

## Timing

- Reset values: `register_we_o=0`, `register_write_index_o=0`, `result_o=0`, `mem_req_o=0`, `mem_we_o=0`, `mem_addr_o=0`, `mem_data_o=0`, `sb_empty_o=1`, `stall_o=0` when `valid_i=0`.
- `stall_o` is combinational from `valid_i`, the inputs, FSM state, buffer state and `mem_ack_i`. All other outputs are registered.
- Non-memory instruction, store, or forwarded load accepted in cycle T: writeback in T+1.
- Load miss accepted-eligible in IDLE at cycle T: `mem_req_o` high in T+1; `mem_ack_i` arrives in T+k; writeback in T+k+1. `stall_o` is high from T through T+k-1.
- If a write is in flight when the load arrives, the load waits for that ack, one IDLE cycle, then the READ.
- Store throughput with a 1-cycle-ack slave: one drain every 3 cycles.

## Configuration

- `CPU_WRITE_SB_FORWARD_EN` defined:
  - Store-to-load forwarding and read priority over drain, as above.
- `CPU_WRITE_SB_FORWARD_EN` undefined:
  - No comparators.
  - Every load stalls until `sb_empty_o=1`, then performs a bus READ. Draining continues while the load waits.
  - Loads never return buffered data.

## Test plan

- **Reset and non-memory instruction.** Assert `rst_i` for 2 cycles; check all outputs are zero and `sb_empty_o=1`. Then present a non-memory op with index 3, value 0x1234, we=1 → next cycle `register_we_o=1`, index 3, `result_o=0x1234`.
- **Full stall.** Ack tied low; 5 stores to 0x10..0x20 at SB_DEPTH=4 → `stall_o` high on the fifth. Release ack → the fifth is accepted after the first pop; memory sees writes in order 0x10, 0x14, 0x18, 0x1C, 0x20.
- **Forwarding, youngest wins.** Store 0xAAAA then 0xBBBB to 0x40 with ack held low, then load 0x40 → no stall, `result_o=0xBBBB` next cycle. With the macro undefined → stall until drained, bus read of 0x40.
- **Load miss behind in-flight write.** Write pending with ack after 3 cycles; load from 0x80 whose slave returns 0xDEAD → READ issued after the write ack plus one IDLE cycle, `result_o=0xDEAD` the cycle after the read ack, `stall_o` low exactly in the ack cycle.
- **Reset mid-operation.** Assert `rst_i` during WRITE with 3 entries buffered → next cycle `mem_req_o=0`, `sb_empty_o=1`, no further writes.
